// File: rtl/chunked_serial_adder_if.sv
// Handshake/data bundle for chunked_serial_adder; carries ovf only when
// CHUNKED_ADDER_OVERFLOW_EN is defined.
interface chunked_serial_adder_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;
`ifdef CHUNKED_ADDER_OVERFLOW_EN
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, busy, ovf
   );
   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, busy, ovf
   );
`else
   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, busy
   );
   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, busy
   );
`endif
endinterface

// File: rtl/chunked_serial_adder.sv
// Multi-cycle adder/subtractor reusing one CHUNK-bit ripple slice WIDTH/CHUNK times.
// Optional signed-overflow output enabled by CHUNKED_ADDER_OVERFLOW_EN.
module chunked_serial_adder #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   chunked_serial_adder_if.slave bus
);
   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state, state_nx;
   logic [WIDTH-1:0]  opa, opb, sum_r;
   logic              carry, cout_r, rdy;
   logic [CW-1:0]     cnt;
   logic [CHUNK-1:0]  ca, cb, cs;
   logic              cc, last, accept;

   assign ca     = opa[int'(cnt)*CHUNK +: CHUNK];
   assign cb     = opb[int'(cnt)*CHUNK +: CHUNK];
   assign last   = (cnt == CW'(NCHUNK - 1));
   assign accept = (state == IDLE) && rdy && bus.in_valid;

   always_comb begin
      {cc, cs} = {1'b0, ca} + {1'b0, cb} + {{CHUNK{1'b0}}, carry};
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = RUN;
         RUN:     if (last) state_nx = DONE;
         DONE:    if (bus.out_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

`ifdef CHUNKED_ADDER_OVERFLOW_EN
   logic ovf_r;
   // carry into the MSB recovered from the slice's top bit: s ^ a ^ b
   always_ff @(posedge clk) begin
      if (!rst_n)
         ovf_r <= 1'b0;
      else if (state == RUN && last)
         ovf_r <= cc ^ (ca[CHUNK-1] ^ cb[CHUNK-1] ^ cs[CHUNK-1]);
   end
   assign bus.ovf = ovf_r;
`endif

   // in_ready is registered so it stays low throughout reset and rises one edge after release
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdy    <= 1'b0;
         opa    <= '0;
         opb    <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum_r  <= '0;
         cout_r <= 1'b0;
      end else begin
         rdy <= (state_nx == IDLE);
         if (accept) begin
            opa   <= bus.a;
            opb   <= bus.b ^ {WIDTH{bus.sub}};
            carry <= bus.cin ^ bus.sub;
            cnt   <= '0;
         end else if (state == RUN) begin
            sum_r[int'(cnt)*CHUNK +: CHUNK] <= cs;
            carry <= cc;
            if (last) cout_r <= cc;
            else      cnt    <= cnt + CW'(1);
         end
      end
   end

   assign bus.in_ready  = rdy;
   assign bus.out_valid = (state == DONE);
   assign bus.busy      = (state != IDLE);
   assign bus.sum       = sum_r;
   assign bus.cout      = cout_r;
endmodule

// File: tb/tb_chunked_serial_adder.sv
// Directed bench for chunked_serial_adder: 8-bit/2-bit-chunk instance plus a
// 4-bit single-chunk instance (ovf checked when CHUNKED_ADDER_OVERFLOW_EN is defined).
module tb_chunked_serial_adder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   chunked_serial_adder_if #(.WIDTH(8)) b8 ();
   chunked_serial_adder_if #(.WIDTH(4)) b4 ();

   chunked_serial_adder #(.WIDTH(8), .CHUNK(2)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
   chunked_serial_adder #(.WIDTH(4), .CHUNK(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic       sub;
      logic [7:0] s;
      logic       c;
   } vec_t;

   vec_t vt[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one operation into the 8-bit instance and wait for its result.
   task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sb,
                       output logic [7:0] s, output logic c);
      int n;
      n = 0;
      while (!b8.in_ready && n < 20) begin tick(); n++; end
      chk("in_ready_idle", 32'(b8.in_ready), 1);
      b8.a = a; b8.b = b; b8.cin = ci; b8.sub = sb; b8.in_valid = 1'b1;
      tick();
      b8.in_valid = 1'b0;
      b8.a = 8'($urandom); b8.b = 8'($urandom); b8.cin = 1'($urandom); b8.sub = 1'($urandom);
      chk("in_ready_run", 32'(b8.in_ready), 0);
      chk("busy_run", 32'(b8.busy), 1);
      n = 0;
      while (!b8.out_valid && n < 20) begin
         tick();
         n++;
         if (!b8.out_valid) chk("in_ready_wait", 32'(b8.in_ready), 0);
      end
      chk("latency8", 32'(n), 4);
      s = b8.sum;
      c = b8.cout;
   endtask

   task automatic handoff8();
      b8.out_ready = 1'b1;
      tick();
      b8.out_ready = 1'b0;
      chk("ov_after_handoff", 32'(b8.out_valid), 0);
      chk("rdy_after_handoff", 32'(b8.in_ready), 1);
      chk("busy_after_handoff", 32'(b8.busy), 0);
   endtask

   initial begin
      logic [7:0] s;
      logic       c;
      int         n;

      vt[0] = '{8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0};
      vt[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1};
      vt[2] = '{8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1};
      vt[3] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0};
      vt[4] = '{8'h20, 8'h10, 1'b1, 1'b1, 8'h0F, 1'b1};
      vt[5] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1};
      vt[6] = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1};
      vt[7] = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0};
      vt[8] = '{8'hA5, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1};
      vt[9] = '{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0};

      b8.in_valid = 1'b0; b8.a = '0; b8.b = '0; b8.cin = 1'b0; b8.sub = 1'b0; b8.out_ready = 1'b0;
      b4.in_valid = 1'b0; b4.a = '0; b4.b = '0; b4.cin = 1'b0; b4.sub = 1'b0; b4.out_ready = 1'b0;

      // Reset state
      rst_n = 1'b0;
      tick(); tick();
      chk("rst_sum", 32'(b8.sum), 0);
      chk("rst_cout", 32'(b8.cout), 0);
      chk("rst_ov", 32'(b8.out_valid), 0);
      chk("rst_busy", 32'(b8.busy), 0);
      chk("rst_rdy", 32'(b8.in_ready), 0);
      rst_n = 1'b1;
      tick();
      chk("rdy_after_rst", 32'(b8.in_ready), 1);

      // Table-driven vectors
      for (int i = 0; i < 10; i++) begin
         run8(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, s, c);
         chk($sformatf("sum[%0d]", i), 32'(s), 32'(vt[i].s));
         chk($sformatf("cout[%0d]", i), 32'(c), 32'(vt[i].c));
         handoff8();
         chk($sformatf("sum_kept[%0d]", i), 32'(b8.sum), 32'(vt[i].s));
      end

      // Backpressure with in_valid asserted during DONE and at handoff
      run8(8'h5A, 8'h3C, 1'b0, 1'b0, s, c);
      b8.a = 8'h11; b8.b = 8'h22; b8.in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("bp_sum", 32'(b8.sum), 32'h96);
         chk("bp_cout", 32'(b8.cout), 0);
         chk("bp_ov", 32'(b8.out_valid), 1);
         chk("bp_rdy", 32'(b8.in_ready), 0);
      end
      b8.out_ready = 1'b1;
      tick();
      b8.out_ready = 1'b0;
      b8.in_valid = 1'b0;
      chk("bp_hand_ov", 32'(b8.out_valid), 0);
      chk("bp_hand_busy", 32'(b8.busy), 0);
      chk("bp_hand_rdy", 32'(b8.in_ready), 1);
      chk("bp_hand_sum", 32'(b8.sum), 32'h96);

      // Reset during RUN at cnt=1
      b8.a = 8'hFF; b8.b = 8'h01; b8.cin = 1'b0; b8.sub = 1'b0; b8.in_valid = 1'b1;
      tick();
      b8.in_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      chk("mid_rst_ov", 32'(b8.out_valid), 0);
      chk("mid_rst_sum", 32'(b8.sum), 0);
      chk("mid_rst_cout", 32'(b8.cout), 0);
      chk("mid_rst_busy", 32'(b8.busy), 0);
      chk("mid_rst_rdy", 32'(b8.in_ready), 0);
      rst_n = 1'b1;
      n = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (b8.out_valid) n++;
      end
      chk("no_result_after_rst", 32'(n), 0);
      run8(8'h5A, 8'h3C, 1'b0, 1'b0, s, c);
      chk("post_rst_sum", 32'(s), 32'h96);
      chk("post_rst_cout", 32'(c), 0);
      handoff8();

      // Single-chunk 4-bit instance: 7+1, then F+1
      for (int k = 0; k < 2; k++) begin
         b4.a = (k == 0) ? 4'h7 : 4'hF; b4.b = 4'h1; b4.cin = 1'b0; b4.sub = 1'b0;
         chk("w4_rdy", 32'(b4.in_ready), 1);
         b4.in_valid = 1'b1;
         tick();
         b4.in_valid = 1'b0;
         chk("w4_busy", 32'(b4.busy), 1);
         n = 0;
         while (!b4.out_valid && n < 20) begin tick(); n++; end
         chk("w4_latency", 32'(n), 1);
         chk("w4_sum", 32'(b4.sum), (k == 0) ? 32'h8 : 32'h0);
         chk("w4_cout", 32'(b4.cout), (k == 0) ? 32'h0 : 32'h1);
`ifdef CHUNKED_ADDER_OVERFLOW_EN
         chk("w4_ovf", 32'(b4.ovf), (k == 0) ? 32'h1 : 32'h0);
`endif
         b4.out_ready = 1'b1;
         tick();
         b4.out_ready = 1'b0;
         chk("w4_hand_ov", 32'(b4.out_valid), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
